io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >=2).
REQ-002 Parameter DEFAULT_DIV, default 16'd16, baud divisor loaded at reset (clock cycles per bit).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 io_we  input  1  IO write strobe from the memory address decoder.
REQ-006 io_addr  input  32  byte offset within the IO window; only io_addr[7:2] decoded.
REQ-007 io_wdata  input  32  store data.
REQ-008 io_rdata  output  32  combinational read data for io_addr, fed to the CPU read mux.
REQ-009 tx  output  1  serial line, idle high, registered.
REQ-010 irq  output  1  interrupt request, registered, level.

Function
REQ-011 Register map (io_addr[7:2]): 0x00 TXDATA, 0x04 STATUS, 0x08 DIV, 0x0C CTRL; other offsets read 0 and ignore writes.
REQ-012 TXDATA write pushes io_wdata[7:0] into FIFO; TXDATA reads 0.
REQ-013 STATUS read = {28'b0, overflow, busy, full, empty}; STATUS write with io_wdata[3]=1 clears overflow; other bits read-only.
REQ-014 DIV read = {16'b0, div}; write loads io_wdata[15:0]; written value 0 stored as 1.
REQ-015 CTRL read = {30'b0, irq_en, enable}; write loads io_wdata[1:0].
REQ-016 io_rdata reflects register state before the current edge; no read side effects.
REQ-017 FSM states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-018 IDLE: tx=1; if enable=1 and FIFO not empty, pop head into shift register, latch div into frame divisor, clear baud counter and bit index, go START.
REQ-019 START drives tx=0, DATA drives shift[bit index] LSB first for 8 bits, STOP drives tx=1; each bit lasts exactly frame divisor cycles.
REQ-020 DATA -> STOP after bit index 7 expires; STOP -> IDLE after one bit time; frame = 10 x frame divisor cycles.
REQ-021 Latency: TXDATA write sampled at edge N with FSM idle and enable=1 -> tx low after edge N+1.
REQ-022 Back-to-back: FIFO non-empty on STOP exit -> IDLE one cycle, next START after following edge (one-cycle idle gap, tx=1).
REQ-023 DIV writes mid-frame do not affect the current frame; applied at next frame start.
REQ-024 enable cleared mid-frame: current frame completes; no further pops while enable=0.
REQ-025 Push while full and no pop same cycle: data dropped, overflow set (sticky).
REQ-026 Push while full with pop same cycle: push accepted, no overflow.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-028 irq registered = irq_en & empty & ~busy, or irq_en & overflow.
REQ-029 io_we=0: no register or FIFO change regardless of io_addr.

Reset
REQ-030 On rst_n=0 at a rising edge: state=IDLE, tx=1, irq=0, FIFO emptied, overflow=0, div=DEFAULT_DIV, CTRL=0.
REQ-031 Reset mid-frame aborts the frame; tx=1 from the next edge; queued bytes discarded.

Verification
REQ-032 DIV=4, CTRL=1, write TXDATA 0xA5 -> tx low 1 cycle after write edge; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; busy 0 after 40 cycles.
REQ-033 DIV=2, CTRL=1, write 0x11,0x22 back-to-back -> two 20-cycle frames separated by one idle-high cycle; STATUS.empty=1 after second pop.
REQ-034 CTRL=0, write 5 bytes (depth 4) -> STATUS=0x0A (overflow, full); write STATUS 0x8 -> overflow=0; set CTRL=1 -> exactly 4 frames sent.
REQ-035 CTRL=3, one byte -> irq=0 while busy, irq=1 after STOP; write DIV 0 -> DIV reads 0x1.
REQ-036 rst_n low at bit 3 of a frame -> next edge tx=1, STATUS=0x1, DIV=DEFAULT_DIV, irq=0.
REQ-037 Write to offset 0x10 and read 0x10 -> no state change, io_rdata=0.

Source files
------------

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped UART transmitter with transmit FIFO, baud divisor and level IRQ
module io_uart_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [15:0]     fdiv_q, fdiv_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            irq_q, irq_d;

  logic [5:0]      sel;
  logic            wr_txdata, wr_status, wr_div, wr_ctrl;
  logic            empty, full, busy, pop, push, ovf_set, bit_done;
  logic            unused_ok;

  // Address bits outside the decoded word index and the upper data bits have no meaning here.
  assign unused_ok = ^{io_addr[31:8], io_addr[1:0], io_wdata[31:16]};

  assign sel       = io_addr[7:2];
  assign wr_txdata = io_we && (sel == 6'd0);
  assign wr_status = io_we && (sel == 6'd1);
  assign wr_div    = io_we && (sel == 6'd2);
  assign wr_ctrl   = io_we && (sel == 6'd3);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign busy     = (state_q != IDLE);
  assign bit_done = (baud_q == fdiv_q - 16'd1);

  // A pop frees a slot on the same edge, so a push into a full FIFO is only dropped without one.
  assign pop     = (state_q == IDLE) && ctrl_q[0] && !empty;
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  assign tx  = tx_q;
  assign irq = irq_q;

  // Register read mux reflects pre-edge state; reads have no side effects.
  always_comb begin
    io_rdata = 32'd0;
    unique case (sel)
      6'd1:    io_rdata = {28'd0, ovf_q, busy, full, empty};
      6'd2:    io_rdata = {16'd0, div_q};
      6'd3:    io_rdata = {30'd0, ctrl_q};
      default: io_rdata = 32'd0;
    endcase
  end

  // Register-file and FIFO bookkeeping next-state.
  always_comb begin
    div_d    = div_q;
    ctrl_d   = ctrl_q;
    ovf_d    = ovf_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_div)  div_d  = (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
    if (wr_ctrl) ctrl_d = io_wdata[1:0];
    if (ovf_set) ovf_d = 1'b1;
    else if (wr_status && io_wdata[3]) ovf_d = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: each non-idle state holds for one bit time of the latched frame divisor.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit-timing datapath: frame divisor and byte are captured at pop so mid-frame DIV writes wait.
  always_comb begin
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fdiv_d    = fdiv_q;
    if (state_q == IDLE) begin
      if (pop) begin
        shift_d   = mem_q[rd_ptr_q];
        fdiv_d    = div_q;
        baud_d    = 16'd0;
        bit_idx_d = 3'd0;
      end
    end else if (bit_done) begin
      baud_d = 16'd0;
      if (state_q == DATA) bit_idx_d = bit_idx_q + 3'd1;
    end else begin
      baud_d = baud_q + 16'd1;
    end
  end

  // FSM outputs, computed from next state so the registered line and irq track the new state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    irq_d = ctrl_d[1] & (((count_d == '0) && (state_d == IDLE)) | ovf_d);
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_wdata[7:0];
  end

  // All remaining state and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DEFAULT_DIV;
      ctrl_q    <= 2'd0;
      fdiv_q    <= DEFAULT_DIV;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      ctrl_q    <= ctrl_d;
      fdiv_q    <= fdiv_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed bench with a frame-level reference model for io_uart_tx
module tb_io_uart_tx;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_DIV = 32'h8, A_CTRL = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        tx, irq;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  io_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus "a frame started at some edge with divisor d".
  logic [7:0]  q[$];
  bit          m_act;
  int          m_el;
  logic [15:0] m_div, m_fdiv;
  logic [1:0]  m_ctrl;
  logic        m_ovf;
  logic [7:0]  m_byte;
  bit          m_pop, m_full;

  function automatic logic fbit(input logic [7:0] b, input int k, input int d);
    int pos;
    pos = k / d;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  function automatic logic m_tx();
    return m_act ? fbit(m_byte, m_el, int'(m_fdiv)) : 1'b1;
  endfunction

  function automatic logic m_irq();
    return m_ctrl[1] & (((q.size() == 0) && !m_act) | m_ovf);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:2])
      6'd1:    return {28'd0, m_ovf, m_act, (q.size() == DEPTH), (q.size() == 0)};
      6'd2:    return {16'd0, m_div};
      6'd3:    return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_act  = 0;
      m_el   = 0;
      m_ovf  = 1'b0;
      m_div  = 16'd16;
      m_fdiv = 16'd16;
      m_ctrl = 2'd0;
    end else begin
      m_pop  = 0;
      m_full = (q.size() == DEPTH);
      if (m_act) begin
        m_el++;
        if (m_el == 10 * int'(m_fdiv)) m_act = 0;
      end else if (m_ctrl[0] && q.size() > 0) begin
        m_pop  = 1;
        m_byte = q.pop_front();
        m_fdiv = m_div;
        m_el   = 0;
        m_act  = 1;
      end
      if (io_we) begin
        case (io_addr[7:2])
          6'd0: if (m_full && !m_pop) m_ovf = 1'b1; else q.push_back(io_wdata[7:0]);
          6'd1: if (io_wdata[3]) m_ovf = 1'b0;
          6'd2: m_div = (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
          6'd3: m_ctrl = io_wdata[1:0];
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_model", {31'd0, tx}, {31'd0, m_tx()});
      chk("irq_model", {31'd0, irq}, {31'd0, m_irq()});
      chk("rdata_model", io_rdata, m_read(io_addr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_we = 1'b1; io_addr = a; io_wdata = d;
    @(posedge clk);
    #1;
    io_we = 1'b0; io_addr = 32'h0; io_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    io_addr = a;
    #1;
    chk(nm, io_rdata, exp);
    io_addr = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame_lit;
    bit done;
    rst_n = 1'b0; io_we = 1'b0; io_addr = 32'h0; io_wdata = 32'h0;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1;

    // Reset values
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(A_ST, 32'h1, "rst_status");
    rd(A_DIV, 32'h10, "rst_div");
    rd(A_CTRL, 32'h0, "rst_ctrl");

    // DIV=4, byte 0xA5: start low one edge after the write, LSB first, 40-cycle frame
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'd1);
    wr(A_TX, 32'hA5);
    chk("a5_idle_before", {31'd0, tx}, 32'd1);
    tick(1);
    frame_lit = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      chk("a5_bit", {31'd0, tx}, {31'd0, frame_lit[k/4]});
      tick(1);
    end
    rd(A_ST, 32'h1, "a5_done_status");

    // DIV=2, two bytes back-to-back with a single idle-high gap
    wr(A_DIV, 32'd2);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    rd(A_ST, 32'h4, "b2b_status_busy");
    tick(20);
    chk("b2b_gap_tx", {31'd0, tx}, 32'd1);
    rd(A_ST, 32'h0, "b2b_gap_status");
    tick(1);
    chk("b2b_second_start", {31'd0, tx}, 32'd0);
    rd(A_ST, 32'h5, "b2b_empty_after_pop");
    tick(20);
    rd(A_ST, 32'h1, "b2b_done");

    // Overflow with transmitter disabled, clear, then exactly four frames
    wr(A_CTRL, 32'd0);
    for (int i = 1; i <= 5; i++) wr(A_TX, i);
    rd(A_ST, 32'hA, "ovf_status");
    wr(A_ST, 32'h8);
    rd(A_ST, 32'h2, "ovf_cleared");
    wr(A_CTRL, 32'd1);
    tick(83);
    rd(A_ST, 32'h5, "four_last_busy");
    tick(1);
    rd(A_ST, 32'h1, "four_done");
    tick(5);
    rd(A_ST, 32'h1, "four_no_fifth");
    chk("four_tx_idle", {31'd0, tx}, 32'd1);

    // Interrupt: low while a frame is pending or in flight, high once idle and empty
    wr(A_CTRL, 32'd3);
    chk("irq_idle_empty", {31'd0, irq}, 32'd1);
    wr(A_TX, 32'h5A);
    chk("irq_pending", {31'd0, irq}, 32'd0);
    tick(20);
    chk("irq_busy", {31'd0, irq}, 32'd0);
    tick(1);
    chk("irq_after_stop", {31'd0, irq}, 32'd1);
    wr(A_DIV, 32'd0);
    rd(A_DIV, 32'h1, "div_zero_as_one");

    // Push into a full FIFO on the same edge as a pop is accepted
    wr(A_CTRL, 32'd0);
    wr(A_DIV, 32'd2);
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h80 + i);
    rd(A_ST, 32'h2, "full_status");
    wr(A_CTRL, 32'd1);
    wr(A_TX, 32'hC3);
    rd(A_ST, 32'h6, "push_pop_full");
    io_addr = A_ST;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1);
      if (io_rdata == 32'h1) done = 1;
    end
    chk("drain_done", {31'd0, done}, 32'd1);
    io_addr = 32'h0;

    // Reset during data bit 3 of a frame
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'd1);
    wr(A_TX, 32'hFF);
    wr(A_TX, 32'h33);
    tick(16);
    chk("bit3_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    rd(A_ST, 32'h1, "midrst_status");
    rd(A_DIV, 32'h10, "midrst_div");
    rst_n = 1'b1;
    tick(12);
    rd(A_ST, 32'h1, "midrst_no_resume");

    // Unmapped offset and io_we low leave state untouched
    wr(A_CTRL, 32'd1);
    wr(A_DIV, 32'd3);
    wr(32'h10, 32'hFFFF_FFFF);
    rd(32'h10, 32'h0, "unmapped_read");
    rd(A_ST, 32'h1, "unmapped_status");
    rd(A_DIV, 32'h3, "unmapped_div");
    rd(A_CTRL, 32'h1, "unmapped_ctrl");
    io_addr = A_TX; io_wdata = 32'h77;
    tick(3);
    io_wdata = 32'h0;
    rd(A_ST, 32'h1, "no_we_status");
    chk("no_we_tx", {31'd0, tx}, 32'd1);

    tick(2);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
